// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// bubble gating of control bits and an optional 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int unsigned OCC_W = 2;

  // Encoding doubles as the occupancy count.
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              accept_c;
  logic              consume_c;

  // Ready: purely state-based with the skid buffer, pass-through of out_ready without it.
  always_comb begin
    if (SKID_EN != 0) begin
      in_ready = (state_q != FULL);
    end else begin
      in_ready = (state_q == EMPTY) || out_ready;
    end
  end

  // Head entry drives the outputs; control is zeroed on bubbles.
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : {CTRL_W{1'b0}};
    occupancy = OCC_W'(state_q);
    accept_c  = in_valid && in_ready;
    consume_c = out_valid && out_ready;
  end

  // Next-state and payload steering; flush overrides accept and consume.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept_c && consume_c) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept_c) begin
            // Only reachable with the skid buffer: without it in_ready is low here.
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (consume_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume_c) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg in both skid and single-entry modes.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned NV = 17;
  localparam int unsigned NRAND = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Skid-mode DUT signals
  logic          f1, iv1, ir1, or1, ov1;
  logic [DW-1:0] d1, od1;
  logic [CW-1:0] c1, oc1;
  logic [1:0]    occ1;
  // Single-entry DUT signals
  logic          f0, iv0, ir0, or0, ov0;
  logic [DW-1:0] d0, od0;
  logic [CW-1:0] c0, oc0;
  logic [1:0]    occ0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1)) dut_skid (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1),
    .in_data(d1), .in_ctrl(c1), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0)) dut_noskid (
    .clk(clk), .rst(rst), .flush(f0), .in_valid(iv0), .in_ready(ir0),
    .in_data(d0), .in_ctrl(c0), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          exp_ir;   // in_ready during the cycle
    logic          exp_ov;   // outputs after the edge
    logic [DW-1:0] exp_od;
    logic [CW-1:0] exp_oc;
    logic [1:0]    exp_occ;
  } vec_t;

  vec_t vecs [NV];

  typedef logic [DW+CW-1:0] ent_t;
  ent_t q1[$];
  ent_t q0[$];

  initial begin
    // fl iv  d       c      ordy ir  ov  od      oc     occ
    vecs[0]  = '{1'b0, 1'b1, 16'h0001, 8'h01, 1'b1, 1'b1, 1'b1, 16'h0001, 8'h01, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 16'h0002, 8'h02, 1'b1, 1'b1, 1'b1, 16'h0002, 8'h02, 2'd1};
    vecs[2]  = '{1'b0, 1'b1, 16'h0003, 8'h03, 1'b1, 1'b1, 1'b1, 16'h0003, 8'h03, 2'd1};
    vecs[3]  = '{1'b0, 1'b1, 16'h0004, 8'h04, 1'b1, 1'b1, 1'b1, 16'h0004, 8'h04, 2'd1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 16'h000A, 8'h0A, 1'b0, 1'b1, 1'b1, 16'h000A, 8'h0A, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 16'h000B, 8'h0B, 1'b0, 1'b1, 1'b1, 16'h000A, 8'h0A, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 16'h000C, 8'h0C, 1'b0, 1'b0, 1'b1, 16'h000A, 8'h0A, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 16'h000C, 8'h0C, 1'b1, 1'b0, 1'b1, 16'h000B, 8'h0B, 2'd1};
    vecs[9]  = '{1'b0, 1'b1, 16'h000C, 8'h0C, 1'b1, 1'b1, 1'b1, 16'h000C, 8'h0C, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 2'd0};
    vecs[11] = '{1'b0, 1'b1, 16'h0011, 8'hFF, 1'b0, 1'b1, 1'b1, 16'h0011, 8'hFF, 2'd1};
    vecs[12] = '{1'b0, 1'b1, 16'h0012, 8'hFF, 1'b0, 1'b1, 1'b1, 16'h0011, 8'hFF, 2'd2};
    vecs[13] = '{1'b1, 1'b1, 16'h0013, 8'h81, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'd0};
    vecs[14] = '{1'b1, 1'b1, 16'h0014, 8'h81, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 2'd0};
    vecs[15] = '{1'b0, 1'b1, 16'h0020, 8'h81, 1'b1, 1'b1, 1'b1, 16'h0020, 8'h81, 2'd1};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 2'd0};

    rst = 1'b1;
    {f1, iv1, d1, c1, or1} = '0;
    {f0, iv0, d0, c0, or0} = '0;
    #1;
    check("reset_ov", 32'(ov1), 32'd0);
    check("reset_oc", 32'(oc1), 32'd0);
    check("reset_od", 32'(od1), 32'd0);
    check("reset_occ", 32'(occ1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ir_skid", 32'(ir1), 32'd1);
    check("reset_ir_noskid", 32'(ir0), 32'd1);

    // Table-driven directed vectors on the skid instance
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      f1 = vecs[i].fl; iv1 = vecs[i].iv; d1 = vecs[i].d; c1 = vecs[i].c; or1 = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(ir1), 32'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(ov1), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_out_ctrl", i), 32'(oc1), 32'(vecs[i].exp_oc));
      check($sformatf("v%0d_occupancy", i), 32'(occ1), 32'(vecs[i].exp_occ));
      if (vecs[i].exp_ov)
        check($sformatf("v%0d_out_data", i), 32'(od1), 32'(vecs[i].exp_od));
    end

    // Async reset with two entries held
    @(negedge clk);
    f1 = 1'b0; iv1 = 1'b1; d1 = 16'h0031; c1 = 8'h31; or1 = 1'b0;
    @(negedge clk);
    d1 = 16'h0032; c1 = 8'h32;
    @(negedge clk);
    iv1 = 1'b0;
    #1;
    check("pre_reset_occ", 32'(occ1), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ov", 32'(ov1), 32'd0);
    check("async_rst_oc", 32'(oc1), 32'd0);
    check("async_rst_occ", 32'(occ1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ir", 32'(ir1), 32'd1);

    // Single-entry mode: replace on simultaneous consume/accept, stall without ready
    @(negedge clk);
    iv0 = 1'b1; d0 = 16'h0005; c0 = 8'h05; or0 = 1'b0;
    #1; check("ns_ir_empty", 32'(ir0), 32'd1);
    @(posedge clk); #1;
    check("ns_od5", 32'(od0), 32'h5);
    check("ns_occ1", 32'(occ0), 32'd1);
    @(negedge clk);
    d0 = 16'h0006; c0 = 8'h06; or0 = 1'b1;
    #1; check("ns_ir_passthru", 32'(ir0), 32'd1);
    @(posedge clk); #1;
    check("ns_od6", 32'(od0), 32'h6);
    check("ns_oc6", 32'(oc0), 32'h6);
    check("ns_occ_still1", 32'(occ0), 32'd1);
    @(negedge clk);
    d0 = 16'h0007; c0 = 8'h07; or0 = 1'b0;
    #1; check("ns_ir_stall", 32'(ir0), 32'd0);
    @(posedge clk); #1;
    check("ns_od_held", 32'(od0), 32'h6);
    @(negedge clk);
    iv0 = 1'b0; or0 = 1'b1;
    @(posedge clk); #1;
    check("ns_drain_ov", 32'(ov0), 32'd0);
    check("ns_drain_oc", 32'(oc0), 32'd0);

    // Random traffic in both modes against queue models
    for (int n = 0; n < int'(NRAND); n++) begin
      logic m_ir1, m_ir0, acc1, acc0, con1, con0;
      @(negedge clk);
      f1 = ($urandom_range(0, 19) == 0); iv1 = ($urandom_range(0, 9) < 7);
      or1 = ($urandom_range(0, 9) < 6); d1 = DW'($urandom); c1 = CW'($urandom);
      f0 = ($urandom_range(0, 19) == 0); iv0 = ($urandom_range(0, 9) < 7);
      or0 = ($urandom_range(0, 9) < 6); d0 = DW'($urandom); c0 = CW'($urandom);
      m_ir1 = (q1.size() < 2);
      m_ir0 = (q0.size() == 0) || or0;
      #1;
      check("rnd_ir_skid", 32'(ir1), 32'(m_ir1));
      check("rnd_ir_noskid", 32'(ir0), 32'(m_ir0));
      acc1 = iv1 && m_ir1; con1 = (q1.size() != 0) && or1;
      acc0 = iv0 && m_ir0; con0 = (q0.size() != 0) && or0;
      @(posedge clk);
      if (f1) q1.delete();
      else begin
        if (con1) q1.delete(0);
        if (acc1) q1.push_back({d1, c1});
      end
      if (f0) q0.delete();
      else begin
        if (con0) q0.delete(0);
        if (acc0) q0.push_back({d0, c0});
      end
      #1;
      check("rnd_occ_skid", 32'(occ1), 32'(q1.size()));
      check("rnd_ov_skid", 32'(ov1), 32'(q1.size() != 0));
      check("rnd_oc_skid", 32'(oc1), (q1.size() != 0) ? 32'(q1[0][CW-1:0]) : 32'd0);
      if (q1.size() != 0) check("rnd_od_skid", 32'(od1), 32'(q1[0][DW+CW-1:CW]));
      check("rnd_occ_noskid", 32'(occ0), 32'(q0.size()));
      check("rnd_ov_noskid", 32'(ov0), 32'(q0.size() != 0));
      check("rnd_oc_noskid", 32'(oc0), (q0.size() != 0) ? 32'(q0[0][CW-1:0]) : 32'd0);
      if (q0.size() != 0) check("rnd_od_noskid", 32'(od0), 32'(q0[0][DW+CW-1:CW]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
